// File: rtl/spiifc_tx_pkg.sv
// Shared SPI interface definitions: tx engine state encoding,
// supported SPI mode and the default byte sent past the requested length.
package spiifc_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRIME,
    ST_SHIFT
  } tx_state_e;

  localparam int unsigned SPI_MODE = 0;
  localparam logic [7:0] DEF_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizer plus one edge-detect register for an async pin.
// Ports: SysClk/Reset, in_i (async pin), lvl_o (synced level), rise_o/fall_o (1-cycle pulses).
module spi_sync_edge #(
  parameter logic RstVal = 1'b0
) (
  input  logic SysClk,
  input  logic Reset,
  input  logic in_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge SysClk) begin
    if (Reset) sync_q <= {3{RstVal}};
    else       sync_q <= {sync_q[1:0], in_i};
  end

  assign lvl_o  = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spiifc_tx.sv
// SPI slave transmit engine (mode 0, MSB first), streams tx memory onto MISO.
// Ports: SPI pins, tx-memory read port, txBaseAddr/txLen request, busy/done/count/overrun status.
module spiifc_tx
  import spiifc_tx_pkg::*;
#(
  parameter int         AddrBits = 12,
  parameter logic [7:0] FillByte = DEF_FILL_BYTE
) (
  input  logic                SysClk,
  input  logic                Reset,
  input  logic                SPI_CLK,
  input  logic                SPI_SS,
  output logic                SPI_MISO,
  output logic [AddrBits-1:0] txMemAddr,
  input  logic [7:0]          txMemData,
  input  logic [AddrBits-1:0] txBaseAddr,
  input  logic [AddrBits:0]   txLen,
  output logic                txBusy,
  output logic                txDone,
  output logic [AddrBits:0]   txByteCount,
  output logic                txOverrun
);

  localparam int LW = AddrBits + 1;

  logic sckLvl, sckRise, sckFall;
  logic ssLvl, ssRise, ssFall;
  logic shiftEdge;
  logic unused_ok;

  spi_sync_edge #(.RstVal(1'b0)) u_sck (
    .SysClk(SysClk), .Reset(Reset), .in_i(SPI_CLK),
    .lvl_o(sckLvl), .rise_o(sckRise), .fall_o(sckFall)
  );

  spi_sync_edge #(.RstVal(1'b1)) u_ss (
    .SysClk(SysClk), .Reset(Reset), .in_i(SPI_SS),
    .lvl_o(ssLvl), .rise_o(ssRise), .fall_o(ssFall)
  );

  assign shiftEdge = (SPI_MODE == 0) ? sckFall : sckRise;
  assign unused_ok = &{1'b0, sckLvl};

  tx_state_e           state_q;
  logic [AddrBits-1:0] addr_q, memAddr_q;
  logic [LW-1:0]       len_q, nextIdx_q, byteCnt_q;
  logic [7:0]          shifter_q, nextByte_q;
  logic                nextFill_q;
  logic [2:0]          bitCnt_q;
  logic [1:0]          rdStage_q;
  logic                miso_q, busy_q, done_q, ovr_q;
  logic                armed_q;
  logic [1:0]          settle_q;

  // armed_q blocks a start when SS was already low across reset:
  // the sync chain's reset value would otherwise fake an SS fall.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      memAddr_q  <= '0;
      len_q      <= '0;
      nextIdx_q  <= '0;
      byteCnt_q  <= '0;
      shifter_q  <= '0;
      nextByte_q <= '0;
      nextFill_q <= 1'b0;
      bitCnt_q   <= '0;
      rdStage_q  <= '0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      armed_q    <= 1'b0;
      settle_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      rdStage_q <= {rdStage_q[0], 1'b0};
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      else if (ssLvl)       armed_q  <= 1'b1;
      // Read data arrives two cycles after the address is registered
      if (rdStage_q[1]) begin
        nextFill_q <= (nextIdx_q >= len_q);
        nextByte_q <= (nextIdx_q >= len_q) ? FillByte : txMemData;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (ssFall && armed_q) begin
            len_q     <= txLen;
            addr_q    <= txBaseAddr;
            memAddr_q <= txBaseAddr;
            byteCnt_q <= '0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_PRIME;
        ST_PRIME: begin
          if (len_q == '0) begin
            shifter_q <= FillByte;
            miso_q    <= FillByte[7];
            ovr_q     <= 1'b1;
          end else begin
            shifter_q <= txMemData;
            miso_q    <= txMemData[7];
          end
          bitCnt_q  <= '0;
          nextIdx_q <= LW'(1);
          memAddr_q <= addr_q + AddrBits'(1);
          rdStage_q <= 2'b01;
          state_q   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (shiftEdge) begin
            if (bitCnt_q != 3'd7) begin
              shifter_q <= shifter_q << 1;
              miso_q    <= shifter_q[6];
              bitCnt_q  <= bitCnt_q + 3'd1;
            end else begin
              shifter_q <= nextByte_q;
              miso_q    <= nextByte_q[7];
              bitCnt_q  <= '0;
              byteCnt_q <= byteCnt_q + LW'(1);
              addr_q    <= addr_q + AddrBits'(1);
              memAddr_q <= addr_q + AddrBits'(2);
              nextIdx_q <= nextIdx_q + LW'(1);
              rdStage_q <= 2'b01;
              if (nextFill_q) ovr_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (ssRise && state_q != ST_IDLE) begin
        state_q <= ST_IDLE;
        miso_q  <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  assign SPI_MISO    = miso_q;
  assign txMemAddr   = memAddr_q;
  assign txBusy      = busy_q;
  assign txDone      = done_q;
  assign txByteCount = byteCnt_q;
  assign txOverrun   = ovr_q;

endmodule
